adc_front_conditioner: RTL and testbench
========================================

ADC_FRONT_CONDITIONER -- requirements
Module: adc_front_conditioner

Interface
REQ-001 SHALL have parameter ADC_BITS, default 14: signed ADC sample width.
REQ-002 SHALL have parameter WIN_BITS, default 16: measurement window of 2^WIN_BITS samples.
REQ-003 SHALL have port adc_clk, input, 1: sole clock; all logic on its rising edge.
REQ-004 SHALL have port adc_rst_n, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have port adc_data_in, input, ADC_BITS: raw signed ADC sample, one per clock.
REQ-006 SHALL have port adc_ovfl_in, input, 1: raw ADC overrange bit, aligned with adc_data_in.
REQ-007 SHALL have port adc_data_out, output, ADC_BITS: registered sample to the receiver.
REQ-008 SHALL have port adc_ovfl_out, output, 1: registered overrange bit, aligned with adc_data_out.
REQ-009 SHALL have port cfg_strobe, input, 1: single-cycle load of cfg_thresh.
REQ-010 SHALL have port cfg_thresh, input, WIN_BITS: minimum overrange count per window that raises ovfl_flag.
REQ-011 SHALL have port ovfl_flag, output, 1: single-cycle pulse at window end when threshold is met.
REQ-012 SHALL have port ovfl_count, output, WIN_BITS: overrange count of the last completed window.
REQ-013 SHALL have port peak_mag, output, ADC_BITS-1: peak magnitude of the last completed window.
REQ-014 SHALL have port win_done, output, 1: single-cycle pulse when ovfl_count/peak_mag update.

Function
REQ-015 SHALL register adc_data_in/adc_ovfl_in to adc_data_out/adc_ovfl_out with exactly 1-cycle latency, no gaps.
REQ-016 SHALL run a WIN_BITS-bit window counter incrementing every cycle, wrapping from 2^WIN_BITS-1 to 0.
REQ-017 SHALL accumulate registered adc_ovfl_out into a running count, saturating at 2^WIN_BITS-1.
REQ-018 SHALL compute magnitude of adc_data_out as |x| truncated to ADC_BITS-1 bits; -2^(ADC_BITS-1) SHALL map to 2^(ADC_BITS-1)-1.
REQ-019 SHALL track running maximum magnitude within the window.
REQ-020 SHALL, on the cycle the window counter equals 2^WIN_BITS-1, include that cycle's sample, then on the next edge latch ovfl_count and peak_mag, pulse win_done, and restart running count and maximum at 0.
REQ-021 SHALL pulse ovfl_flag together with win_done iff threshold != 0 and final count >= threshold.
REQ-022 SHALL treat threshold 0 as detection disabled (ovfl_flag never asserts; ovfl_count still updates).
REQ-023 SHALL load cfg_thresh on cfg_strobe at the next edge; a strobe coinciding with window end SHALL NOT affect that window's comparison (old threshold used).
REQ-024 SHALL hold ovfl_count and peak_mag stable between win_done pulses.

Reset
REQ-025 SHALL, while adc_rst_n=0 at a clock edge, clear adc_data_out, adc_ovfl_out, ovfl_flag, win_done, ovfl_count, peak_mag, window counter, running count, running maximum, and threshold to 0.
REQ-026 SHALL, on reset mid-window, discard the partial window; first win_done occurs 2^WIN_BITS+1 cycles after first cycle with adc_rst_n=1.

Configuration
REQ-027 SHALL implement peak tracking (REQ-018, REQ-019, peak_mag latch) only when macro ADC_PEAK_HOLD_EN is defined.
REQ-028 SHALL, without ADC_PEAK_HOLD_EN, tie peak_mag to 0 and remove magnitude logic; all other behaviour unchanged.

Verification (bench uses WIN_BITS=4, ADC_BITS=14)
REQ-029 SHALL cover: ramp adc_data_in 0..100 -> adc_data_out equals input delayed exactly 1 cycle, no drops.
REQ-030 SHALL cover: cfg_thresh=3, adc_ovfl_in high 3 of 16 samples -> ovfl_count=3, ovfl_flag and win_done pulse same cycle; next window 2 samples -> count=2, no flag.
REQ-031 SHALL cover: adc_ovfl_in high all 16 samples -> ovfl_count=15 (saturated), flag with threshold 15.
REQ-032 SHALL cover: samples {100, -8192, 50} in one window with ADC_PEAK_HOLD_EN -> peak_mag=8191; without macro -> peak_mag=0.
REQ-033 SHALL cover: cfg_strobe with cfg_thresh=0 on window-end cycle, window count 5 vs old threshold 4 -> flag this window, no flag next window.
REQ-034 SHALL cover: adc_rst_n low 2 cycles at window position 7 -> all outputs 0, next win_done 17 cycles after reset release.

Source files
------------

// File: rtl/adc_front_conditioner.sv
// Registers a raw ADC stream and gathers per-window overrange statistics.
// Peak-magnitude tracking is built only when ADC_PEAK_HOLD_EN is defined.
module adc_front_conditioner #(
  parameter int ADC_BITS = 14,
  parameter int WIN_BITS = 16
) (
  input  logic                adc_clk,
  input  logic                adc_rst_n,
  input  logic [ADC_BITS-1:0] adc_data_in,
  input  logic                adc_ovfl_in,
  output logic [ADC_BITS-1:0] adc_data_out,
  output logic                adc_ovfl_out,
  input  logic                cfg_strobe,
  input  logic [WIN_BITS-1:0] cfg_thresh,
  output logic                ovfl_flag,
  output logic [WIN_BITS-1:0] ovfl_count,
  output logic [ADC_BITS-2:0] peak_mag,
  output logic                win_done
);

  // All-ones is both the last window position and the count saturation value.
  localparam logic [WIN_BITS-1:0] WIN_LAST = {WIN_BITS{1'b1}};

  logic [ADC_BITS-1:0] data_d, data_q;
  logic                ovfl_d, ovfl_q;
  logic [WIN_BITS-1:0] win_cnt_d, win_cnt_q;
  logic [WIN_BITS-1:0] run_cnt_d, run_cnt_q;
  logic [WIN_BITS-1:0] thresh_d, thresh_q;
  logic [WIN_BITS-1:0] ovfl_count_d, ovfl_count_q;
  logic                win_done_d, win_done_q;
  logic                ovfl_flag_d, ovfl_flag_q;
  logic                win_end;
  logic [WIN_BITS-1:0] cnt_sum;

  always_comb begin
    // NOTE: every always_comb target gets a default first so no path can infer a latch.
    data_d    = adc_data_in;
    ovfl_d    = adc_ovfl_in;
    win_end   = (win_cnt_q == WIN_LAST);
    win_cnt_d = win_cnt_q + WIN_BITS'(1);

    cnt_sum = run_cnt_q;
    if (ovfl_q && (run_cnt_q != WIN_LAST)) cnt_sum = run_cnt_q + WIN_BITS'(1);

    // The last sample of the window is folded in before the result is latched.
    run_cnt_d    = win_end ? '0 : cnt_sum;
    ovfl_count_d = win_end ? cnt_sum : ovfl_count_q;
    win_done_d   = win_end;
    ovfl_flag_d  = win_end && (thresh_q != '0) && (cnt_sum >= thresh_q);

    // A strobe on the window-end cycle lands after that window's comparison.
    thresh_d = cfg_strobe ? cfg_thresh : thresh_q;
  end

  always_ff @(posedge adc_clk) begin
    if (!adc_rst_n) begin
      data_q       <= '0;
      ovfl_q       <= 1'b0;
      win_cnt_q    <= '0;
      run_cnt_q    <= '0;
      thresh_q     <= '0;
      ovfl_count_q <= '0;
      win_done_q   <= 1'b0;
      ovfl_flag_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample pre-edge values.
      data_q       <= data_d;
      ovfl_q       <= ovfl_d;
      win_cnt_q    <= win_cnt_d;
      run_cnt_q    <= run_cnt_d;
      thresh_q     <= thresh_d;
      ovfl_count_q <= ovfl_count_d;
      win_done_q   <= win_done_d;
      ovfl_flag_q  <= ovfl_flag_d;
    end
  end

  assign adc_data_out = data_q;
  assign adc_ovfl_out = ovfl_q;
  assign ovfl_count   = ovfl_count_q;
  assign win_done     = win_done_q;
  assign ovfl_flag    = ovfl_flag_q;

`ifdef ADC_PEAK_HOLD_EN
  localparam int MAG_BITS = ADC_BITS - 1;

  logic [ADC_BITS-1:0] neg_data;
  logic [MAG_BITS-1:0] mag, max_sel;
  logic [MAG_BITS-1:0] run_max_d, run_max_q;
  logic [MAG_BITS-1:0] peak_d, peak_q;

  always_comb begin
    neg_data = -data_q;
    mag      = data_q[MAG_BITS-1:0];
    if (data_q[ADC_BITS-1]) begin
      // The most-negative code has no positive twin, so it clamps to full scale.
      if (data_q[MAG_BITS-1:0] == '0) mag = '1;
      else                            mag = neg_data[MAG_BITS-1:0];
    end
    max_sel   = (mag > run_max_q) ? mag : run_max_q;
    run_max_d = win_end ? '0 : max_sel;
    peak_d    = win_end ? max_sel : peak_q;
  end

  always_ff @(posedge adc_clk) begin
    if (!adc_rst_n) begin
      run_max_q <= '0;
      peak_q    <= '0;
    end else begin
      run_max_q <= run_max_d;
      peak_q    <= peak_d;
    end
  end

  assign peak_mag = peak_q;
`else
  assign peak_mag = '0;
`endif

endmodule

// File: tb/tb_adc_front_conditioner.sv
// Randomised and directed stimulus for adc_front_conditioner, checked by a
// scoreboard fed from a window-level reference model (WIN_BITS=4, ADC_BITS=14).
module tb_adc_front_conditioner;

  localparam int ADC_BITS = 14;
  localparam int WIN_BITS = 4;
  localparam int WIN_LEN  = 16;
  localparam int CNT_MAX  = 15;
  localparam int MAG_MAX  = 8191;
`ifdef ADC_PEAK_HOLD_EN
  localparam bit PEAK_EN = 1'b1;
`else
  localparam bit PEAK_EN = 1'b0;
`endif

  logic                       adc_clk = 1'b0;
  logic                       adc_rst_n;
  logic signed [ADC_BITS-1:0] adc_data_in;
  logic                       adc_ovfl_in;
  logic signed [ADC_BITS-1:0] adc_data_out;
  logic                       adc_ovfl_out;
  logic                       cfg_strobe;
  logic [WIN_BITS-1:0]        cfg_thresh;
  logic                       ovfl_flag;
  logic [WIN_BITS-1:0]        ovfl_count;
  logic [ADC_BITS-2:0]        peak_mag;
  logic                       win_done;

  adc_front_conditioner #(.ADC_BITS(ADC_BITS), .WIN_BITS(WIN_BITS)) dut (
    .adc_clk      (adc_clk),
    .adc_rst_n    (adc_rst_n),
    .adc_data_in  (adc_data_in),
    .adc_ovfl_in  (adc_ovfl_in),
    .adc_data_out (adc_data_out),
    .adc_ovfl_out (adc_ovfl_out),
    .cfg_strobe   (cfg_strobe),
    .cfg_thresh   (cfg_thresh),
    .ovfl_flag    (ovfl_flag),
    .ovfl_count   (ovfl_count),
    .peak_mag     (peak_mag),
    .win_done     (win_done)
  );

  always #5 adc_clk = ~adc_clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input longint actual, input longint expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct { int data; bit ovfl; } samp_t;
  typedef struct { int data; bit ovfl; int count; int peak; } out_exp_t;
  typedef struct { int count; int peak; bit flag; } win_res_t;

  out_exp_t exp_out_q[$];
  win_res_t exp_win_q[$];
  samp_t    window[$];
  samp_t    cur_out;
  int       m_pos, m_thresh, hold_count, hold_peak;
  int       m_sum, m_pk;
  win_res_t m_res;
  out_exp_t m_exp;

  function automatic int mag_of(input int x);
    int m;
    m = (x < 0) ? -x : x;
    return (m > MAG_MAX) ? MAG_MAX : m;
  endfunction

  // A window is the 16 registered output samples seen while the counter runs 0..15.
  always @(posedge adc_clk) begin : model
    if (!adc_rst_n) begin
      window.delete();
      exp_win_q.delete();
      m_pos = 0; m_thresh = 0; hold_count = 0; hold_peak = 0;
      cur_out.data = 0; cur_out.ovfl = 1'b0;
    end else begin
      window.push_back(cur_out);
      if (m_pos == WIN_LEN - 1) begin
        m_sum = 0; m_pk = 0;
        foreach (window[i]) begin
          m_sum += int'(window[i].ovfl);
          if (mag_of(window[i].data) > m_pk) m_pk = mag_of(window[i].data);
        end
        m_res.count = (m_sum > CNT_MAX) ? CNT_MAX : m_sum;
        m_res.peak  = PEAK_EN ? m_pk : 0;
        m_res.flag  = (m_thresh != 0) && (m_res.count >= m_thresh);
        exp_win_q.push_back(m_res);
        hold_count = m_res.count;
        hold_peak  = m_res.peak;
        window.delete();
        m_pos = 0;
      end else begin
        m_pos++;
      end
      if (cfg_strobe) m_thresh = int'(cfg_thresh);
      cur_out.data = int'(adc_data_in);
      cur_out.ovfl = adc_ovfl_in;
    end
    m_exp.data  = cur_out.data;
    m_exp.ovfl  = cur_out.ovfl;
    m_exp.count = hold_count;
    m_exp.peak  = hold_peak;
    exp_out_q.push_back(m_exp);
  end

  // ---------------- monitor ----------------
  out_exp_t mon_e;
  win_res_t mon_w;
  bit       mon_has_win;

  always @(negedge adc_clk) begin : monitor
    if (exp_out_q.size() != 0) begin
      mon_e = exp_out_q.pop_front();
      check("data_out",   adc_data_out, mon_e.data);
      check("ovfl_out",   adc_ovfl_out, mon_e.ovfl);
      check("ovfl_count", ovfl_count,   mon_e.count);
      check("peak_mag",   peak_mag,     mon_e.peak);
      mon_has_win = (exp_win_q.size() != 0);
      check("win_done", win_done, mon_has_win);
      if (mon_has_win) begin
        mon_w = exp_win_q.pop_front();
        check("ovfl_flag", ovfl_flag, mon_w.flag);
      end else begin
        check("ovfl_flag_idle", ovfl_flag, 0);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic put(input int d, input bit o);
    adc_data_in = ADC_BITS'(d);
    adc_ovfl_in = o;
    cfg_strobe  = 1'b0;
  endtask

  task automatic set_thresh(input int t);
    cfg_strobe = 1'b1;
    cfg_thresh = WIN_BITS'(t);
  endtask

  // Returns at the negedge of the cycle in which the window counter reads p.
  task automatic goto_pos(input int p);
    for (int i = 0; i < 40; i++) begin
      @(negedge adc_clk);
      put(0, 1'b0);
      if (m_pos == p) return;
    end
    check("goto_pos_timeout", m_pos, p);
  endtask

  // Samples driven from the pos-15 cycle onward land in the next window in order.
  task automatic send_window(input logic [15:0] mask, input int d0, input int d1, input int d2);
    goto_pos(WIN_LEN - 1);
    for (int i = 0; i < WIN_LEN; i++) begin
      if (i != 0) @(negedge adc_clk);
      put((i == 0) ? d0 : (i == 1) ? d1 : (i == 2) ? d2 : 0, mask[i]);
    end
  endtask

  task automatic wait_win();
    for (int i = 0; i < 40; i++) begin
      @(negedge adc_clk);
      put(0, 1'b0);
      if (win_done) return;
    end
    check("win_done_timeout", win_done, 1);
  endtask

  int n_rel;

  initial begin
    adc_rst_n  = 1'b0;
    cfg_thresh = '0;
    put(0, 1'b0);
    repeat (3) @(negedge adc_clk);
    check("rst_data_out",   adc_data_out, 0);
    check("rst_ovfl_count", ovfl_count,   0);
    check("rst_win_done",   win_done,     0);
    adc_rst_n = 1'b1;

    // Ramp: every output must equal the previous cycle's input.
    for (int i = 0; i <= 100; i++) begin
      @(negedge adc_clk);
      put(i, 1'b0);
    end

    // Threshold 3: three overranges flag, then two do not.
    @(negedge adc_clk); put(0, 1'b0); set_thresh(3);
    send_window(16'b0000_0100_1000_0010, 0, 0, 0);
    wait_win();
    check("thr3_count", ovfl_count, 3);
    check("thr3_flag",  ovfl_flag,  1);
    send_window(16'b0001_0000_0000_1000, 0, 0, 0);
    wait_win();
    check("two_count", ovfl_count, 2);
    check("two_flag",  ovfl_flag,  0);

    // Every sample overranged: count saturates at 15 and meets threshold 15.
    @(negedge adc_clk); put(0, 1'b0); set_thresh(15);
    send_window(16'hFFFF, 0, 0, 0);
    wait_win();
    check("sat_count", ovfl_count, CNT_MAX);
    check("sat_flag",  ovfl_flag,  1);

    // Most-negative sample sets the peak to full scale.
    send_window(16'h0000, 100, -8192, 50);
    wait_win();
    check("peak_neg_full", peak_mag, PEAK_EN ? MAG_MAX : 0);

    // Disabling the threshold on the window-end cycle still uses the old value.
    @(negedge adc_clk); put(0, 1'b0); set_thresh(4);
    send_window(16'b1000_0101_0010_0001, 0, 0, 0);
    @(negedge adc_clk); put(0, 1'b0); set_thresh(0);
    wait_win();
    check("old_thr_count", ovfl_count, 5);
    check("old_thr_flag",  ovfl_flag,  1);
    send_window(16'b1000_0101_0010_0001, 0, 0, 0);
    wait_win();
    check("disabled_count", ovfl_count, 5);
    check("disabled_flag",  ovfl_flag,  0);

    // Reset mid-window at position 7 for two cycles.
    goto_pos(7);
    adc_rst_n = 1'b0;
    repeat (2) @(negedge adc_clk);
    check("mid_rst_count", ovfl_count,   0);
    check("mid_rst_ovfl",  adc_ovfl_out, 0);
    check("mid_rst_flag",  ovfl_flag,    0);
    adc_rst_n = 1'b1;
    n_rel = 1;
    while (!win_done && n_rel < 40) begin
      @(negedge adc_clk);
      put(0, 1'b0);
      n_rel++;
    end
    check("rst_to_win_done", n_rel, WIN_LEN + 1);

    // Random traffic with occasional threshold loads and short resets.
    for (int i = 0; i < 400; i++) begin
      @(negedge adc_clk);
      put(int'($urandom_range(16383)) - 8192, $urandom_range(2) == 0);
      if ($urandom_range(19) == 0) set_thresh(int'($urandom_range(15)));
      adc_rst_n = ($urandom_range(149) != 0);
    end
    @(negedge adc_clk);
    adc_rst_n = 1'b1;
    put(0, 1'b0);
    repeat (40) @(negedge adc_clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
